// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA raster timing generator and its renderers:
//   - default 640x480@60 (25.175 MHz) timing set
//   - 800x600@60 (40 MHz) timing set
//   - sync polarity constants
//   - test-pattern colour constants and bar colour lookup
//   - bar edge helper used to build the divider-free bar index ladder
// ---------------------------------------------------------------------------
package vga_pkg;

    // 640x480@60 timing
    localparam int VGA640_H_VISIBLE = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_VISIBLE = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;

    // 800x600@60 timing, 40 MHz pixel clock, both syncs active-high
    localparam int SVGA800_H_VISIBLE = 800;
    localparam int SVGA800_H_FP      = 40;
    localparam int SVGA800_H_SYNC    = 128;
    localparam int SVGA800_H_BP      = 88;
    localparam int SVGA800_V_VISIBLE = 600;
    localparam int SVGA800_V_FP      = 1;
    localparam int SVGA800_V_SYNC    = 4;
    localparam int SVGA800_V_BP      = 23;

    // Sync polarity (value of the sync pin while sync is asserted)
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // Deepest supported extra delay on hs/vs/de
    localparam int PIPE_DLY_MAX = 7;

    // 3-bit RGB test-pattern colours, {r,g,b}
    typedef enum logic [2:0] {
        TP_BLACK   = 3'b000,
        TP_BLUE    = 3'b001,
        TP_GREEN   = 3'b010,
        TP_CYAN    = 3'b011,
        TP_RED     = 3'b100,
        TP_MAGENTA = 3'b101,
        TP_YELLOW  = 3'b110,
        TP_WHITE   = 3'b111
    } tp_color_e;

    // Colour of each of the eight vertical bars, left to right
    function automatic tp_color_e tp_bar_color(input logic [2:0] bar_idx);
        tp_color_e c;
        case (bar_idx)
            3'd0:    c = TP_BLACK;
            3'd1:    c = TP_BLUE;
            3'd2:    c = TP_GREEN;
            3'd3:    c = TP_CYAN;
            3'd4:    c = TP_RED;
            3'd5:    c = TP_MAGENTA;
            3'd6:    c = TP_YELLOW;
            3'd7:    c = TP_WHITE;
            default: c = TP_BLACK;
        endcase
        return c;
    endfunction

    // First x belonging to bar k: smallest x with x*8/h_visible >= k,
    // i.e. ceil(k*h_visible/8). Evaluated at elaboration only.
    function automatic int tp_bar_edge(input int k, input int h_visible);
        return (k * h_visible + 7) / 8;
    endfunction

endpackage

// File: rtl/vga_dly_line.sv
// ---------------------------------------------------------------------------
// vga_dly_line
// Clock-enable qualified shift register used to delay the sync/DE bundle
// (and test-pattern colour) so it lines up with downstream pixel pipelines.
// Stages advance only when ce is high; a low rst_n at a clock edge clears
// every stage to zero regardless of ce.
//
// Parameters:
//   WIDTH  bits per stage
//   DEPTH  number of stages (>= 1; a zero-depth path is a wire in the parent)
// Ports:
//   clk    clock
//   rst_n  synchronous clear, active-low
//   ce     stage advance enable
//   d      input word
//   q      word delayed by DEPTH ce cycles
// ---------------------------------------------------------------------------
module vga_dly_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_dly_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register: clear on reset, shift one stage per enabled clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else if (ce) begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Produces pixel coordinates,
// zero-latency active/line/frame strobes, and delayed hs/vs/de whose
// latency (PIPE_DLY+1 ce cycles) matches the renderer pixel pipeline.
//
// Build option: define VGA_TIMING_TESTPAT_EN to add a 3-bit rgb output with
// an 8-bar test pattern and white 1-pixel border, aligned with de.
//
// Ports:
//   clk          pixel-domain clock
//   rst_n        synchronous reset, active-low (ce ignored while low)
//   ce           pixel clock enable; all state advances only when high
//   x, y         current raster position
//   active       x < H_VISIBLE and y < V_VISIBLE (undelayed)
//   line_start   high while x == 0
//   frame_start  high while x == 0 and y == 0
//   hs, vs       delayed syncs with polarity HS_POL / VS_POL
//   de           delayed active
//   frame_count  completed frames, wraps at 256
//   rgb          (VGA_TIMING_TESTPAT_EN only) test pattern, delayed like de
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE = VGA640_H_VISIBLE,
    parameter int   H_FP      = VGA640_H_FP,
    parameter int   H_SYNC    = VGA640_H_SYNC,
    parameter int   H_BP      = VGA640_H_BP,
    parameter int   V_VISIBLE = VGA640_V_VISIBLE,
    parameter int   V_FP      = VGA640_V_FP,
    parameter int   V_SYNC    = VGA640_V_SYNC,
    parameter int   V_BP      = VGA640_V_BP,
    parameter logic HS_POL    = POL_ACTIVE_LOW,
    parameter logic VS_POL    = POL_ACTIVE_LOW,
    parameter int   PIPE_DLY  = 1,
    parameter int   CW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [7:0]    frame_count
`ifdef VGA_TIMING_TESTPAT_EN
    ,
    output logic [2:0]    rgb
`endif
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_VISIBLE + H_FP;
    localparam int HS_LAST  = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FP;
    localparam int VS_LAST  = V_VISIBLE + V_FP + V_SYNC - 1;

    if ((H_TOTAL > (32'sd1 << CW)) || (V_TOTAL > (32'sd1 << CW))) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
    end
    if ((PIPE_DLY < 0) || (PIPE_DLY > PIPE_DLY_MAX)) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..7");
    end

    localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_VIS      = CW'(H_VISIBLE);
    localparam logic [CW-1:0] Y_VIS      = CW'(V_VISIBLE);
    localparam logic [CW-1:0] X_HS_FIRST = CW'(HS_FIRST);
    localparam logic [CW-1:0] X_HS_LAST  = CW'(HS_LAST);
    localparam logic [CW-1:0] Y_VS_FIRST = CW'(VS_FIRST);
    localparam logic [CW-1:0] Y_VS_LAST  = CW'(VS_LAST);

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int RAW_W = 6;
`else
    localparam int RAW_W = 3;
`endif

    logic [CW-1:0]    x_r;
    logic [CW-1:0]    y_r;
    logic [7:0]       frame_count_r;
    logic             active_s;
    logic             line_start_s;
    logic             frame_start_s;
    logic             hs_raw_s;
    logic             vs_raw_s;
    logic [RAW_W-1:0] raw_s;
    logic [RAW_W-1:0] dly_s;
    logic             hs_r;
    logic             vs_r;
    logic             de_r;

    // Raster counters: x wraps per line, y per frame, frame_count per frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r           <= '0;
            y_r           <= '0;
            frame_count_r <= 8'd0;
        end else if (ce) begin
            if (x_r == X_LAST) begin
                x_r <= '0;
                if (y_r == Y_LAST) begin
                    y_r           <= '0;
                    frame_count_r <= frame_count_r + 8'd1;
                end else begin
                    y_r <= y_r + CW'(1);
                end
            end else begin
                x_r <= x_r + CW'(1);
            end
        end
    end

    // Zero-latency position decodes; vs spans whole lines since it depends on y only
    always_comb begin
        active_s      = (x_r < X_VIS) && (y_r < Y_VIS);
        line_start_s  = (x_r == '0);
        frame_start_s = (x_r == '0) && (y_r == '0);
        hs_raw_s      = (x_r >= X_HS_FIRST) && (x_r <= X_HS_LAST);
        vs_raw_s      = (y_r >= Y_VS_FIRST) && (y_r <= Y_VS_LAST);
    end

`ifdef VGA_TIMING_TESTPAT_EN
    // Bar boundaries as constants so the bar index needs no divider
    localparam logic [CW-1:0] BAR_E1 = CW'(tp_bar_edge(1, H_VISIBLE));
    localparam logic [CW-1:0] BAR_E2 = CW'(tp_bar_edge(2, H_VISIBLE));
    localparam logic [CW-1:0] BAR_E3 = CW'(tp_bar_edge(3, H_VISIBLE));
    localparam logic [CW-1:0] BAR_E4 = CW'(tp_bar_edge(4, H_VISIBLE));
    localparam logic [CW-1:0] BAR_E5 = CW'(tp_bar_edge(5, H_VISIBLE));
    localparam logic [CW-1:0] BAR_E6 = CW'(tp_bar_edge(6, H_VISIBLE));
    localparam logic [CW-1:0] BAR_E7 = CW'(tp_bar_edge(7, H_VISIBLE));
    localparam logic [CW-1:0] X_VIS_LAST = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] Y_VIS_LAST = CW'(V_VISIBLE - 1);

    logic [2:0] bar_idx_s;
    logic       border_s;
    logic [2:0] rgb_raw_s;
    logic [2:0] rgb_r;

    // Test pattern: bar index ladder, border override, black outside active
    always_comb begin
        if (x_r >= BAR_E7) begin
            bar_idx_s = 3'd7;
        end else if (x_r >= BAR_E6) begin
            bar_idx_s = 3'd6;
        end else if (x_r >= BAR_E5) begin
            bar_idx_s = 3'd5;
        end else if (x_r >= BAR_E4) begin
            bar_idx_s = 3'd4;
        end else if (x_r >= BAR_E3) begin
            bar_idx_s = 3'd3;
        end else if (x_r >= BAR_E2) begin
            bar_idx_s = 3'd2;
        end else if (x_r >= BAR_E1) begin
            bar_idx_s = 3'd1;
        end else begin
            bar_idx_s = 3'd0;
        end

        border_s = (x_r == '0) || (x_r == X_VIS_LAST) ||
                   (y_r == '0) || (y_r == Y_VIS_LAST);

        if (!active_s) begin
            rgb_raw_s = 3'd0;
        end else if (border_s) begin
            rgb_raw_s = TP_WHITE;
        end else begin
            rgb_raw_s = tp_bar_color(bar_idx_s);
        end
    end
`endif

    // Bundle carried through the delay line, all bits asserted-high
    always_comb begin
`ifdef VGA_TIMING_TESTPAT_EN
        raw_s = {rgb_raw_s, active_s, vs_raw_s, hs_raw_s};
`else
        raw_s = {active_s, vs_raw_s, hs_raw_s};
`endif
    end

    if (PIPE_DLY > 0) begin : g_dly
        vga_dly_line #(
            .WIDTH (RAW_W),
            .DEPTH (PIPE_DLY)
        ) u_dly (
            .clk   (clk),
            .rst_n (rst_n),
            .ce    (ce),
            .d     (raw_s),
            .q     (dly_s)
        );
    end else begin : g_nodly
        assign dly_s = raw_s;
    end

    // Output stage: final delay register, where sync polarity is applied
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_r  <= ~HS_POL;
            vs_r  <= ~VS_POL;
            de_r  <= 1'b0;
`ifdef VGA_TIMING_TESTPAT_EN
            rgb_r <= 3'd0;
`endif
        end else if (ce) begin
            hs_r  <= dly_s[0] ? HS_POL : ~HS_POL;
            vs_r  <= dly_s[1] ? VS_POL : ~VS_POL;
            de_r  <= dly_s[2];
`ifdef VGA_TIMING_TESTPAT_EN
            rgb_r <= dly_s[5:3];
`endif
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign active      = active_s;
    assign line_start  = line_start_s;
    assign frame_start = frame_start_s;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign de          = de_r;
    assign frame_count = frame_count_r;
`ifdef VGA_TIMING_TESTPAT_EN
    assign rgb         = rgb_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances share clk/rst_n/ce:
//   dut 0: small 16x6 mode (23x10 total), hs active-low, vs active-high,
//          PIPE_DLY=3 -- short frames so whole-frame behaviour is reachable
//   dut 1: default 640x480, PIPE_DLY=1, active-low syncs
//   dut 2: default 640x480, PIPE_DLY=0, active-high syncs
// The reference model counts enabled clocks since reset and derives every
// output from that count with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int P_HV   [3] = '{16, 640, 640};
    localparam int P_HFP  [3] = '{2, 16, 16};
    localparam int P_HSY  [3] = '{3, 96, 96};
    localparam int P_HBP  [3] = '{2, 48, 48};
    localparam int P_VV   [3] = '{6, 480, 480};
    localparam int P_VFP  [3] = '{1, 10, 10};
    localparam int P_VSY  [3] = '{2, 2, 2};
    localparam int P_VBP  [3] = '{1, 33, 33};
    localparam int P_HPOL [3] = '{0, 0, 1};
    localparam int P_VPOL [3] = '{1, 0, 1};
    localparam int P_DLY  [3] = '{3, 1, 0};

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] fc;
        logic [2:0] rgb;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic [4:0] xa, ya;
    logic [9:0] xb, yb, xc, yc;
    logic [2:0] act_o, ls_o, fs_o, hs_o, vs_o, de_o;
    logic [7:0] fc_o [3];
`ifdef VGA_TIMING_TESTPAT_EN
    logic [2:0] rgb_o [3];
`endif

    int n;       // enabled clocks since last reset
    int tests;
    int fails;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(3), .CW(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(xa), .y(ya),
        .active(act_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0]),
        .hs(hs_o[0]), .vs(vs_o[0]), .de(de_o[0]), .frame_count(fc_o[0])
`ifdef VGA_TIMING_TESTPAT_EN
        , .rgb(rgb_o[0])
`endif
    );

    vga_timing_gen dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(xb), .y(yb),
        .active(act_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1]),
        .hs(hs_o[1]), .vs(vs_o[1]), .de(de_o[1]), .frame_count(fc_o[1])
`ifdef VGA_TIMING_TESTPAT_EN
        , .rgb(rgb_o[1])
`endif
    );

    vga_timing_gen #(
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .ce(ce), .x(xc), .y(yc),
        .active(act_o[2]), .line_start(ls_o[2]), .frame_start(fs_o[2]),
        .hs(hs_o[2]), .vs(vs_o[2]), .de(de_o[2]), .frame_count(fc_o[2])
`ifdef VGA_TIMING_TESTPAT_EN
        , .rgb(rgb_o[2])
`endif
    );

    // Reference: what dut d shows after nn enabled clocks since reset
    function automatic st_t exp_state(input int d, input int nn);
        st_t e;
        int ht, vt, ft, pos, xx, yy, lat, p2, x2, y2;
        ht = P_HV[d] + P_HFP[d] + P_HSY[d] + P_HBP[d];
        vt = P_VV[d] + P_VFP[d] + P_VSY[d] + P_VBP[d];
        ft = ht * vt;
        pos = nn % ft;
        xx = pos % ht;
        yy = pos / ht;
        e = '0;
        e.x      = 10'(xx);
        e.y      = 10'(yy);
        e.fc     = 8'((nn / ft) % 256);
        e.active = (xx < P_HV[d]) && (yy < P_VV[d]);
        e.ls     = (xx == 0);
        e.fs     = (pos == 0);
        lat = P_DLY[d] + 1;
        if (nn >= lat) begin
            p2 = (nn - lat) % ft;
            x2 = p2 % ht;
            y2 = p2 / ht;
            e.hs = ((x2 >= P_HV[d] + P_HFP[d]) && (x2 < P_HV[d] + P_HFP[d] + P_HSY[d]))
                   ? 1'(P_HPOL[d]) : 1'(1 - P_HPOL[d]);
            e.vs = ((y2 >= P_VV[d] + P_VFP[d]) && (y2 < P_VV[d] + P_VFP[d] + P_VSY[d]))
                   ? 1'(P_VPOL[d]) : 1'(1 - P_VPOL[d]);
            e.de = (x2 < P_HV[d]) && (y2 < P_VV[d]);
`ifdef VGA_TIMING_TESTPAT_EN
            // bars are in binary colour order, so colour == bar number
            if (e.de) begin
                if (x2 == 0 || x2 == P_HV[d] - 1 || y2 == 0 || y2 == P_VV[d] - 1)
                    e.rgb = 3'd7;
                else
                    e.rgb = 3'((x2 * 8) / P_HV[d]);
            end
`endif
        end else begin
            e.hs = 1'(1 - P_HPOL[d]);
            e.vs = 1'(1 - P_VPOL[d]);
        end
        return e;
    endfunction

    function automatic st_t obs_state(input int d);
        st_t o;
        o = '0;
        case (d)
            0:       begin o.x = {5'd0, xa}; o.y = {5'd0, ya}; end
            1:       begin o.x = xb; o.y = yb; end
            default: begin o.x = xc; o.y = yc; end
        endcase
        o.active = act_o[d];
        o.ls     = ls_o[d];
        o.fs     = fs_o[d];
        o.hs     = hs_o[d];
        o.vs     = vs_o[d];
        o.de     = de_o[d];
        o.fc     = fc_o[d];
`ifdef VGA_TIMING_TESTPAT_EN
        o.rgb    = rgb_o[d];
`endif
        return o;
    endfunction

    // One clock: drive at negedge, advance model at posedge, return at negedge
    task automatic tick(input logic ce_v, input logic rst_v);
        ce    = ce_v;
        rst_n = rst_v;
        @(posedge clk);
        if (!rst_v) n = 0;
        else if (ce_v) n = n + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        st_t o, e;
        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom_range(0, 1)), 1'b0);
            for (int d = 0; d < 3; d++) begin
                o = obs_state(d);
                e = exp_state(d, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL reset dut%0d cyc%0d: got %h want %h", d, i, o, e);
                end
            end
        end
    endtask

    task automatic test_free_run();
        st_t o, e;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 700; i++) begin
            tick(1'b1, 1'b1);
            for (int d = 0; d < 3; d++) begin
                o = obs_state(d);
                e = exp_state(d, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL free_run dut%0d n%0d: got %h want %h", d, n, o, e);
                end
            end
        end
    endtask

    task automatic test_hs_width();
        int b_first = -1;
        int b_w = 0;
        int c_first = -1;
        int c_w = 0;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            tick(1'b1, 1'b1);
            if (hs_o[1] == 1'b0) begin
                if (b_first < 0) b_first = int'(xb);
                b_w++;
            end
            if (hs_o[2] == 1'b1) begin
                if (c_first < 0) c_first = int'(xc);
                c_w++;
            end
        end
        tests++;
        if (b_first != 658) begin fails++; $display("FAIL hs_start_dly1: got x=%0d want 658", b_first); end
        tests++;
        if (b_w != 96) begin fails++; $display("FAIL hs_width_dly1: got %0d want 96", b_w); end
        tests++;
        if (c_first != 657) begin fails++; $display("FAIL hs_start_pos_dly0: got x=%0d want 657", c_first); end
        tests++;
        if (c_w != 96) begin fails++; $display("FAIL hs_width_pos_dly0: got %0d want 96", c_w); end
    endtask

    task automatic test_ce_quarter();
        st_t o, e;
        int low_clks = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3400; i++) begin
            tick((i % 4) == 3, 1'b1);
            if (hs_o[1] == 1'b0) low_clks++;
            for (int d = 0; d < 3; d++) begin
                o = obs_state(d);
                e = exp_state(d, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL ce_quarter dut%0d clk%0d: got %h want %h", d, i, o, e);
                end
            end
        end
        tests++;
        if (low_clks != 384) begin
            fails++;
            $display("FAIL hs_width_quarter_ce: got %0d clocks want 384", low_clks);
        end
    endtask

    task automatic test_random_ce();
        st_t o, e;
        logic c;
        for (int i = 0; i < 2000; i++) begin
            c = ($urandom_range(0, 2) != 0);
            tick(c, 1'b1);
            for (int d = 0; d < 3; d++) begin
                o = obs_state(d);
                e = exp_state(d, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL random_ce dut%0d n%0d: got %h want %h", d, n, o, e);
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        st_t o, e;
        for (int i = 0; i < 300 + int'($urandom_range(0, 60)); i++) begin
            tick(1'b1, 1'b1);
        end
        tick(1'($urandom_range(0, 1)), 1'b0);
        for (int d = 0; d < 3; d++) begin
            o = obs_state(d);
            e = exp_state(d, n);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_reset dut%0d: got %h want %h", d, o, e);
            end
        end
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b1);
            for (int d = 0; d < 3; d++) begin
                o = obs_state(d);
                e = exp_state(d, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL after_reset dut%0d n%0d: got %h want %h", d, n, o, e);
                end
            end
        end
    endtask

`ifdef VGA_TIMING_TESTPAT_EN
    task automatic test_testpat();
        st_t o, e;
        logic [3:0] want;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            tick(1'b1, 1'b1);
            for (int d = 0; d < 2; d++) begin
                o = obs_state(d);
                e = exp_state(d, n);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL testpat dut%0d n%0d: got %h want %h", d, n, o, e);
                end
            end
            // default mode, latency 2: observed at n shows raster position n-2 (line 1)
            if (n == 802 || n == 902 || n == 1441 || n == 1502) begin
                case (n)
                    802:     want = 4'b1_111;
                    902:     want = 4'b1_001;
                    1441:    want = 4'b1_111;
                    default: want = 4'b0_000;
                endcase
                tests++;
                if ({de_o[1], rgb_o[1]} !== want) begin
                    fails++;
                    $display("FAIL testpat_point n%0d: got de/rgb %b want %b", n, {de_o[1], rgb_o[1]}, want);
                end
            end
        end
    endtask
`endif

    initial begin
        n     = 0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ce    = 1'b0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_hs_width();
        test_ce_quarter();
        test_random_ce();
        test_mid_frame_reset();
`ifdef VGA_TIMING_TESTPAT_EN
        test_testpat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
